// File: rtl/uart_rx_deser_param_if.sv
// Bus between the RX front end / consumer and the parametrised UART RX deserializer.
// "master" drives the sampler, control and consumer side; "slave" is the deserializer.
interface uart_rx_deser_param_if #(
  parameter int MAX_DATA_WIDTH = 9,
  parameter int PRESCALE_WIDTH = 6
);
  logic                      deser_en;
  logic [PRESCALE_WIDTH-1:0] edge_cnt;
  logic [PRESCALE_WIDTH-1:0] Prescale;
  logic                      sampled_bit;
  logic [3:0]                data_len;
  logic                      msb_first;
  logic                      out_ready;
  logic                      ovr_clr;
  logic [MAX_DATA_WIDTH-1:0] P_DATA;
  logic                      out_valid;
  logic                      overrun;
  logic [3:0]                bit_count;

  modport master (
    output deser_en, edge_cnt, Prescale, sampled_bit, data_len, msb_first, out_ready, ovr_clr,
    input  P_DATA, out_valid, overrun, bit_count
  );
  modport slave (
    input  deser_en, edge_cnt, Prescale, sampled_bit, data_len, msb_first, out_ready, ovr_clr,
    output P_DATA, out_valid, overrun, bit_count
  );
endinterface

// File: rtl/uart_rx_deser_param.sv
// UART RX deserializer: runtime length 5..MAX_DATA_WIDTH, LSB/MSB-first order,
// one-entry valid/ready output register with a sticky overrun flag.
module uart_rx_deser_param #(
  parameter int MAX_DATA_WIDTH = 9,
  parameter int PRESCALE_WIDTH = 6
) (
  input logic                   CLK,
  input logic                   RST,
  uart_rx_deser_param_if.slave  bus
);
  localparam logic [3:0] MAX_L = 4'(MAX_DATA_WIDTH);

  typedef enum logic [1:0] {IDLE, COLLECT, COMMIT} state_e;

  state_e                    state_q, state_d;
  logic [MAX_DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [MAX_DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic [3:0]                bit_count_q, bit_count_d;
  logic                      out_valid_q, out_valid_d;
  logic                      overrun_q, overrun_d;

  logic [3:0]                len;
  logic [3:0]                shamt;
  logic [PRESCALE_WIDTH-1:0] samp_pt;
  logic                      capture;

  always_comb begin
    len     = (bus.data_len >= 4'd5 && bus.data_len <= MAX_L) ? bus.data_len : MAX_L;
    shamt   = MAX_L - len;
    samp_pt = (bus.Prescale == PRESCALE_WIDTH'(4)) ? (bus.Prescale >> 1)
                                                   : (bus.Prescale >> 1) + PRESCALE_WIDTH'(1);
    capture = bus.deser_en && (bus.edge_cnt == samp_pt) && (bit_count_q < len);
  end

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bit_count_d = bit_count_q;
    p_data_d    = p_data_q;
    out_valid_d = out_valid_q && !bus.out_ready;
    overrun_d   = overrun_q && !bus.ovr_clr;

    if (capture) begin
      shreg_d     = bus.msb_first ? {shreg_q[MAX_DATA_WIDTH-2:0], bus.sampled_bit}
                                  : {bus.sampled_bit, shreg_q[MAX_DATA_WIDTH-1:1]};
      bit_count_d = bit_count_q + 4'd1;
    end

    case (state_q)
      IDLE: if (capture) state_d = COLLECT;
      COLLECT: begin
        if (bit_count_q == len) begin
          state_d = COMMIT;
        end else if (!bus.deser_en && bit_count_q != 4'd0) begin
          // Frame abandoned mid-data: drop the partial word, leave the output alone.
          state_d     = IDLE;
          bit_count_d = 4'd0;
          shreg_d     = '0;
        end
      end
      COMMIT: begin
        // LSB-first words sit in the top L bits; MSB-first words in the bottom L bits.
        p_data_d    = bus.msb_first ? (shreg_q & ({MAX_DATA_WIDTH{1'b1}} >> shamt))
                                    : (shreg_q >> shamt);
        out_valid_d = 1'b1;
        if (out_valid_q && !bus.out_ready) overrun_d = 1'b1;
        bit_count_d = 4'd0;
        shreg_d     = '0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      p_data_q    <= '0;
      bit_count_q <= 4'd0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      p_data_q    <= p_data_d;
      bit_count_q <= bit_count_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.P_DATA    = p_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.overrun   = overrun_q;
  assign bus.bit_count = bit_count_q;
endmodule

// File: tb/tb_uart_rx_deser_param.sv
// Directed and randomized frames against a word-level model of the deserializer's
// output register (expected word, valid and overrun tracked per frame).
module tb_uart_rx_deser_param;
  localparam int MAXW = 9;
  localparam int PW   = 6;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  uart_rx_deser_param_if #(.MAX_DATA_WIDTH(MAXW), .PRESCALE_WIDTH(PW)) bus ();
  uart_rx_deser_param #(.MAX_DATA_WIDTH(MAXW), .PRESCALE_WIDTH(PW)) dut (
    .CLK(CLK), .RST(RST), .bus(bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // Word-level reference state
  logic [31:0] m_data = 0;
  logic        m_valid = 0;
  logic        m_ovr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    @(negedge CLK);
    chk({tag, ".data"},   32'(bus.P_DATA),    m_data);
    chk({tag, ".valid"},  32'(bus.out_valid), 32'(m_valid));
    chk({tag, ".ovr"},    32'(bus.overrun),   32'(m_ovr));
    chk({tag, ".bitcnt"}, 32'(bus.bit_count), 0);
  endtask

  // Streams nsend bits of a frame (pre edges per bit), then idle cycles with deser_en low.
  // rdy_c raises out_ready exactly for the commit edge.
  task automatic send_frame(input logic [14:0] data, input logic [3:0] dl, input bit msb,
                            input int pre, input int nsend, input int idle, input bit rdy_c);
    int len, s, since, bi, e;
    logic [31:0] word;
    len   = (dl >= 5 && dl <= MAXW) ? int'(dl) : MAXW;
    s     = (pre == 4) ? 2 : pre / 2 + 1;
    word  = 32'(data) & ((32'd1 << len) - 1);
    since = -1;
    for (int k = 0; k < nsend * pre + idle; k++) begin
      @(negedge CLK);
      if (since >= 0) since++;
      if (since == 1) chk("bitcnt_full", 32'(bus.bit_count), 32'(len));
      if (since == 2) begin
        chk("pre_commit_valid", 32'(bus.out_valid), 32'(m_valid));
        bus.out_ready = rdy_c;
      end
      if (since == 3) begin
        chk("commit_data", 32'(bus.P_DATA), word);
        bus.out_ready = 1'b0;
      end
      if (k < nsend * pre) begin
        bi = k / pre;
        e  = k % pre;
        bus.deser_en    = 1'b1;
        bus.edge_cnt    = PW'(e);
        bus.sampled_bit = msb ? data[len-1-bi] : data[bi];
        bus.data_len    = dl;
        bus.msb_first   = msb;
        bus.Prescale    = PW'(pre);
        if (bi == len - 1 && e == s) since = 0;
      end else begin
        bus.deser_en = 1'b0;
        bus.edge_cnt = '0;
      end
    end
    if (nsend == len) begin
      if (m_valid && !rdy_c) m_ovr = 1'b1;
      m_data  = word;
      m_valid = 1'b1;
    end
  endtask

  task automatic consume();
    @(negedge CLK); bus.out_ready = 1'b1;
    @(negedge CLK); bus.out_ready = 1'b0;
    m_valid = 1'b0;
    chk("consume.valid", 32'(bus.out_valid), 0);
    chk("consume.hold",  32'(bus.P_DATA), m_data);
  endtask

  task automatic clear_ovr();
    @(negedge CLK); bus.ovr_clr = 1'b1;
    @(negedge CLK); bus.ovr_clr = 1'b0;
    m_ovr = 1'b0;
    chk("ovr_clr", 32'(bus.overrun), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int pres[4];
    logic [14:0] rd;
    logic [3:0]  rdl;
    pres = '{4, 8, 16, 32};
    bus.deser_en = 0; bus.edge_cnt = 0; bus.Prescale = 6'd8; bus.sampled_bit = 0;
    bus.data_len = 4'd8; bus.msb_first = 0; bus.out_ready = 0; bus.ovr_clr = 0;

    repeat (3) @(negedge CLK);
    RST = 1'b1;
    check_all("reset");

    // LSB-first 8 bits 1,0,1,1,0,0,1,0
    send_frame(15'h04D, 4'd8, 1'b0, 8, 8, 4, 1'b0);
    check_all("lsb8");
    chk("lsb8.const", 32'(bus.P_DATA), 32'h4D);
    consume();

    // MSB-first 5 bits 1,0,0,1,1 at Prescale 4
    send_frame(15'h013, 4'd5, 1'b1, 4, 5, 4, 1'b0);
    check_all("msb5");
    consume();

    // Full width at Prescale 32, then data_len=3 clamped to 9
    send_frame(15'h1A5, 4'd9, 1'b0, 32, 9, 4, 1'b0);
    check_all("w9");
    consume();
    send_frame(15'h1A5, 4'd3, 1'b0, 32, 9, 4, 1'b0);
    check_all("clamp");

    // Commit coinciding with consumer pop: no overrun
    send_frame(15'h00F, 4'd8, 1'b0, 8, 8, 4, 1'b1);
    check_all("commit_pop");
    consume();

    // Overrun on back-to-back unconsumed words
    send_frame(15'h055, 4'd8, 1'b0, 8, 8, 4, 1'b0);
    send_frame(15'h0AA, 4'd8, 1'b0, 8, 8, 4, 1'b0);
    check_all("overrun");
    clear_ovr();
    consume();

    // Abort after 4 of 8 bits
    send_frame(15'h0FF, 4'd8, 1'b0, 8, 4, 0, 1'b0);
    @(negedge CLK);
    chk("abort.partial", 32'(bus.bit_count), 4);
    bus.deser_en = 1'b0;
    check_all("abort");
    send_frame(15'h03C, 4'd8, 1'b0, 8, 8, 4, 1'b0);
    check_all("after_abort");
    send_frame(15'h012, 4'd8, 1'b1, 8, 8, 4, 1'b0);
    check_all("pre_reset_ovr");

    // Reset in the middle of bit 5
    send_frame(15'h0FF, 4'd8, 1'b0, 8, 4, 0, 1'b0);
    @(negedge CLK); bus.edge_cnt = 6'd0;
    @(negedge CLK); bus.edge_cnt = 6'd1;
    @(negedge CLK); bus.edge_cnt = 6'd2; RST = 1'b0;
    @(negedge CLK); RST = 1'b1; bus.deser_en = 1'b0; bus.edge_cnt = 6'd0;
    m_data = 0; m_valid = 0; m_ovr = 0;
    check_all("midreset");
    send_frame(15'h081, 4'd8, 1'b0, 8, 8, 4, 1'b0);
    check_all("after_reset");
    consume();

    // Randomized frames
    for (int n = 0; n < 24; n++) begin
      rd  = 15'($urandom);
      rdl = 4'($urandom_range(0, 15));
      send_frame(rd, rdl, 1'($urandom_range(0, 1)), pres[$urandom_range(0, 3)],
                 (rdl >= 5 && rdl <= MAXW) ? int'(rdl) : MAXW, 4, ($urandom_range(0, 3) == 0));
      check_all("rand");
      if ($urandom_range(0, 1) == 1) consume();
      if ($urandom_range(0, 3) == 0) clear_ovr();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
